data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//   Memory-side responder for the CPU data-memory interface: word-addressed 32-bit RAM behind
//   a valid/ready request channel and a valid/ready response channel, with programmable wait
//   states. Sits where the CPU's data_memory_a/wd/we/rd bus terminates; it is the slave end
//   that the multicycle/pipelined core will drive when memory is no longer single-cycle.
// PARAMETERS
//   ADDR_WIDTH  6  word-address bits; RAM depth = 2**ADDR_WIDTH words
//   LATENCY     2  wait cycles between request accept and access commit (0..15)
// PORTS
//   clk        in   1   clock, all state updates on posedge
//   rst_n      in   1   asynchronous active-low reset
//   req_valid  in   1   request present
//   req_ready  out  1   responder can accept a request this cycle
//   req_we     in   1   1 = write, 0 = read
//   req_addr   in   32  byte address (word aligned expected)
//   req_wd     in   32  write data
//   resp_valid out  1   response present
//   resp_ready in   1   requester takes response this cycle
//   resp_rd    out  32  read data (0 for writes and errors)
//   resp_err   out  1   misaligned or out-of-range access
// BEHAVIOUR
//   - Reset (async, rst_n=0): state IDLE, req_ready=0 while rst_n=0 then 1, resp_valid=0,
//     resp_rd=0, resp_err=0, wait counter=0. RAM contents are not cleared (unchanged/X).
//   - FSM: IDLE -> (LATENCY>0 ? WAIT : RESP) on accept; WAIT -> RESP when counter reaches 0;
//     RESP -> IDLE on resp_ready. req_ready=1 only in IDLE; resp_valid=1 only in RESP.
//   - Accept = req_valid & req_ready at posedge: latch we/addr/wd, load counter=LATENCY-1.
//   - Commit edge = edge entering RESP: write RAM[addr[ADDR_WIDTH+1:2]] <= wd, or capture
//     RAM word into resp_rd. resp_valid first high LATENCY+1 cycles after the accept edge.
//   - Error: addr[1:0]!=0 or addr[31:ADDR_WIDTH+2]!=0 -> no RAM write, resp_rd=0, resp_err=1,
//     same latency as a normal access.
//   - Response held stable (rd, err) while resp_valid & !resp_ready; no timeout.
//   - No new accept in WAIT/RESP even if resp_ready and req_valid coincide; next accept
//     earliest in the IDLE cycle after the response handshake. Throughput: 1 per LATENCY+2
//     cycles min.
//   - Read after write to same address returns the written value (write committed before).
//   - Reset mid-operation: pending access is dropped; a write not yet committed never lands.
//   - req_* ignored outside IDLE; X on req_addr outside accept must not corrupt state.
// STRUCTURE
//   - Shared package/header (alongside util.v): state encodings ST_IDLE/ST_WAIT/ST_RESP,
//     WORD_BYTES=4, error-check helper macro.
//   - One sub-module: word_ram (sync write, sync read, 32-bit, depth param, no reset).
//   - Top: FSM, wait counter, request latch, error decode, response register.
// TESTING
//   1 Reset: rst_n=0 mid-WAIT -> next cycle resp_valid=0, req_ready=1 after release, no write.
//   2 Write 0xDEADBEEF @0x10 then read @0x10 (LATENCY=2) -> resp_valid 3 cycles after each
//     accept, resp_rd=0xDEADBEEF, resp_err=0.
//   3 Read @0x0000_0102 (misaligned) -> resp_err=1, resp_rd=0; write @0x100 (out of range,
//     ADDR_WIDTH=6) -> resp_err=1, later read @0x0 unchanged.
//   4 Backpressure: resp_ready=0 for 5 cycles -> resp_valid/resp_rd stable, req_ready=0;
//     req_valid held high meanwhile is accepted only in IDLE after the handshake.
//   5 LATENCY=0 build: write 0x1 @0x4, read @0x4 -> resp_valid cycle after accept, rd=0x1.
//   6 Wrap: write top word @0xFC=0x5A5A5A5A, write @0x0=0x1 -> both read back distinct.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM states, word size, address checks.
package data_mem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned BYTE_BITS  = $clog2(WORD_BYTES);

    // Misaligned byte address, or any address bit set above the RAM's word index range.
    function automatic logic addr_err(input logic [31:0] addr, input int unsigned addr_width);
        return (addr[BYTE_BITS-1:0] != '0) || ((addr >> (addr_width + BYTE_BITS)) != '0);
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response channel between the CPU data port (master) and the memory responder (slave).
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wd;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rd;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wd, resp_ready,
        input  req_ready, resp_valid, resp_rd, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wd, resp_ready,
        output req_ready, resp_valid, resp_rd, resp_err
    );
endinterface

// File: rtl/data_mem_responder_word_ram.sv
// Single-port 32-bit word RAM: synchronous write, synchronous read, contents not reset.
module word_ram #(
    parameter int unsigned ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wd,
    output logic [31:0]           rd
);
    logic [31:0] mem [2**ADDR_WIDTH];

    // Write port and read register; rd only moves on a read so it can serve as the response word.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wd;
        if (re) rd <= mem[addr];
    end
endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder: accepts one request, waits LATENCY cycles, commits, holds the response.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned LATENCY    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    data_mem_responder_if.slave  bus
);
    localparam logic [3:0] CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    state_t                state, state_nxt;
    logic [3:0]            cnt;
    logic                  lat_we, lat_err;
    logic [ADDR_WIDTH-1:0] lat_idx;
    logic [31:0]           lat_wd;
    logic                  accept, commit;
    logic                  cur_we, cur_err;
    logic [ADDR_WIDTH-1:0] cur_idx;
    logic [31:0]           cur_wd;
    logic                  ram_we, ram_re;
    logic [31:0]           ram_rd;
    logic                  rd_sel, err_q;

    assign bus.req_ready  = rst_n && (state == ST_IDLE);
    assign bus.resp_valid = (state == ST_RESP);
    assign accept         = bus.req_valid && bus.req_ready;
    assign commit         = (state_nxt == ST_RESP) && (state != ST_RESP);

    // With LATENCY=0 the commit edge is the accept edge, so the access is taken straight from the bus.
    assign cur_we  = (state == ST_IDLE) ? bus.req_we : lat_we;
    assign cur_err = (state == ST_IDLE) ? addr_err(bus.req_addr, ADDR_WIDTH) : lat_err;
    assign cur_idx = (state == ST_IDLE) ? bus.req_addr[ADDR_WIDTH+BYTE_BITS-1:BYTE_BITS] : lat_idx;
    assign cur_wd  = (state == ST_IDLE) ? bus.req_wd : lat_wd;
    assign ram_we  = commit && cur_we && !cur_err;
    assign ram_re  = commit && !cur_we && !cur_err;

    assign bus.resp_rd  = rd_sel ? ram_rd : '0;
    assign bus.resp_err = err_q;

    word_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .re   (ram_re),
        .addr (cur_idx),
        .wd   (cur_wd),
        .rd   (ram_rd)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = (LATENCY == 0) ? ST_RESP : ST_WAIT;
            ST_WAIT: if (cnt == '0) state_nxt = ST_RESP;
            ST_RESP: if (bus.resp_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Wait-state counter, loaded on accept and run down while waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                             cnt <= '0;
        else if (accept)                        cnt <= CNT_INIT;
        else if (state == ST_WAIT && cnt != '0) cnt <= cnt - 4'd1;
    end

    // Request latch, captured only on accept so bus activity outside IDLE is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_we  <= 1'b0;
            lat_err <= 1'b0;
            lat_idx <= '0;
            lat_wd  <= '0;
        end else if (accept) begin
            lat_we  <= bus.req_we;
            lat_err <= addr_err(bus.req_addr, ADDR_WIDTH);
            lat_idx <= bus.req_addr[ADDR_WIDTH+BYTE_BITS-1:BYTE_BITS];
            lat_wd  <= bus.req_wd;
        end
    end

    // Response flags set on the commit edge and held until the next commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_sel <= 1'b0;
            err_q  <= 1'b0;
        end else if (commit) begin
            rd_sel <= ram_re;
            err_q  <= cur_err;
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench: LATENCY=2 and LATENCY=0 responders against an array reference model.
module tb_data_mem_responder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0;          // 0: LATENCY=2 instance, 1: LATENCY=0 instance
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wd = '0;
    logic        resp_ready = 1'b0;

    logic        obs_req_ready, obs_resp_valid, obs_resp_err;
    logic [31:0] obs_resp_rd;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] mem_m [2][64];
    bit          known [2][64];

    data_mem_responder_if bus0 ();
    data_mem_responder_if bus1 ();

    assign bus0.req_valid  = req_valid && !sel;
    assign bus0.req_we     = req_we;
    assign bus0.req_addr   = req_addr;
    assign bus0.req_wd     = req_wd;
    assign bus0.resp_ready = resp_ready;
    assign bus1.req_valid  = req_valid && sel;
    assign bus1.req_we     = req_we;
    assign bus1.req_addr   = req_addr;
    assign bus1.req_wd     = req_wd;
    assign bus1.resp_ready = resp_ready;

    always_comb begin
        obs_req_ready  = sel ? bus1.req_ready  : bus0.req_ready;
        obs_resp_valid = sel ? bus1.resp_valid : bus0.resp_valid;
        obs_resp_rd    = sel ? bus1.resp_rd    : bus0.resp_rd;
        obs_resp_err   = sel ? bus1.resp_err   : bus0.resp_err;
    end

    data_mem_responder #(.ADDR_WIDTH(6), .LATENCY(2)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    data_mem_responder #(.ADDR_WIDTH(6), .LATENCY(0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete transaction with latency, hold-stability and handshake checks.
    task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          input int hold, input bit keep);
        int          lat;
        bit          got;
        bit          err;
        int          idx;
        logic [31:0] exp_rd;
        bit          rd_known;
        lat = sel ? 0 : 2;
        err = (addr % 4 != 0) || (addr >= 32'd256);
        idx = int'(addr / 4) % 64;
        exp_rd   = (we || err) ? 32'h0 : mem_m[sel][idx];
        rd_known = we || err || known[sel][idx];
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wd = wd;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            if (obs_req_ready) begin got = 1; break; end
            @(negedge clk);
        end
        chk("accept_ready", 32'(got), 32'd1);
        @(posedge clk); #1;
        if (!keep) begin
            req_valid = 1'b0; req_we = $urandom; req_addr = $urandom; req_wd = $urandom;
        end
        for (int i = 0; i <= lat; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            chk("resp_valid_latency", 32'(obs_resp_valid), 32'(i == lat));
            chk("req_ready_busy", 32'(obs_req_ready), 32'd0);
        end
        if (rd_known) chk("resp_rd", obs_resp_rd, exp_rd);
        chk("resp_err", 32'(obs_resp_err), 32'(err));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(obs_resp_valid), 32'd1);
            if (rd_known) chk("hold_rd", obs_resp_rd, exp_rd);
            chk("hold_err", 32'(obs_resp_err), 32'(err));
            chk("hold_req_ready", 32'(obs_req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk("post_hs_valid", 32'(obs_resp_valid), 32'd0);
        chk("post_hs_idle_ready", 32'(obs_req_ready), 32'd1);
        if (we && !err) begin
            mem_m[sel][idx] = wd;
            known[sel][idx] = 1;
        end
    endtask

    initial begin
        #300000;
        n_fail++;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [31:0] a;
        // Reset values while rst_n is low.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(obs_req_ready), 32'd0);
        chk("rst_resp_valid", 32'(obs_resp_valid), 32'd0);
        chk("rst_resp_rd", obs_resp_rd, 32'h0);
        chk("rst_resp_err", 32'(obs_resp_err), 32'd0);
        @(negedge clk); rst_n = 1'b1; #1;
        chk("rst_release_ready", 32'(obs_req_ready), 32'd1);

        // Write then read back.
        do_txn(1'b1, 32'h10, 32'hDEADBEEF, 0, 0);
        do_txn(1'b0, 32'h10, 32'h0, 0, 0);

        // Reset during WAIT: pending write must never land.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wd = 32'h12345678;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("abort_in_wait", 32'(obs_resp_valid), 32'd0);
        @(negedge clk); rst_n = 1'b0; #1;
        chk("abort_resp_valid", 32'(obs_resp_valid), 32'd0);
        chk("abort_req_ready", 32'(obs_req_ready), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1; #1;
        chk("abort_release_ready", 32'(obs_req_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        chk("abort_no_resp", 32'(obs_resp_valid), 32'd0);
        do_txn(1'b0, 32'h10, 32'h0, 0, 0);

        // Error cases: misaligned read, out-of-range write aliasing word 0.
        do_txn(1'b1, 32'h0, 32'hCAFEF00D, 0, 0);
        do_txn(1'b0, 32'h0000_0102, 32'h0, 0, 0);
        do_txn(1'b1, 32'h100, 32'h0BADBAD0, 0, 0);
        do_txn(1'b0, 32'h0, 32'h0, 0, 0);

        // Backpressure with a second request held valid throughout.
        do_txn(1'b0, 32'h10, 32'h0, 5, 1);
        do_txn(1'b0, 32'h0, 32'h0, 0, 0);

        // Wrap: top word and word 0 stay distinct.
        do_txn(1'b1, 32'hFC, 32'h5A5A5A5A, 0, 0);
        do_txn(1'b1, 32'h0, 32'h1, 0, 0);
        do_txn(1'b0, 32'hFC, 32'h0, 0, 0);
        do_txn(1'b0, 32'h0, 32'h0, 1, 0);

        // Randomized traffic on the LATENCY=2 instance.
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 5))
                0:       a = ($urandom_range(0, 63) * 4) | $urandom_range(1, 3);
                1:       a = ($urandom & 32'hFFFF_FFFC) | 32'h100;
                default: a = $urandom_range(0, 63) * 4;
            endcase
            do_txn(1'($urandom), a, $urandom, $urandom_range(0, 3), 0);
        end

        // LATENCY=0 instance.
        sel = 1'b1;
        do_txn(1'b1, 32'h4, 32'h1, 0, 0);
        do_txn(1'b0, 32'h4, 32'h0, 2, 0);
        do_txn(1'b0, 32'h6, 32'h0, 0, 0);
        for (int n = 0; n < 20; n++) begin
            a = $urandom_range(0, 7) * 4;
            do_txn(1'($urandom), a, $urandom, $urandom_range(0, 2), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
